// File: rtl/cpu7_prog_loader_if.sv
// Byte-stream in / program-RAM write port out for the cpu7 program loader.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready is part of the bundle; the loader holds it at 1.
// Ports (signals):
//   in_data/in_valid/in_ready      byte stream, transfer = in_valid & in_ready
//   prog_we/prog_addr/prog_data    program RAM write port (1-cycle strobe)
// Modports: master = byte source / RAM side, slave = loader side.
interface cpu7_prog_loader_if #(
  parameter int ADDR_W      = 10,
  parameter int INSTR_WIDTH = 16
);
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   prog_we;
  logic [ADDR_W-1:0]      prog_addr;
  logic [INSTR_WIDTH-1:0] prog_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, prog_we, prog_addr, prog_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, prog_we, prog_addr, prog_data
  );
endinterface

// File: rtl/cpu7_prog_loader.sv
// Loads cpu7 program RAM from a framed byte stream and holds the cores in reset until done.
// Latency: RAM write strobe 1 cycle after the last byte of a word; status flags 1 cycle after state change.
// Backpressure: none, in_ready is always 1; every byte is consumed in the cycle it is valid.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   bus (slave)     byte stream in, program RAM write port out
//   cpu_hold_o      reset request to cores (1 until a good image is loaded)
//   load_done_o     last load completed successfully
//   load_err_o      last load failed, sticky until the next SYNC_BYTE
// Frame: SYNC, LEN_LO, LEN_HI, LEN*NBYTES data bytes (little-endian per word), [CSUM].
// Optional feature macro: CPU7_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module cpu7_prog_loader #(
  parameter int         PROGRAM_SIZE   = 1024,
  parameter int         INSTR_WIDTH    = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic               clk,
  input  logic               rst,
  cpu7_prog_loader_if.slave  bus,
  output logic               cpu_hold_o,
  output logic               load_done_o,
  output logic               load_err_o
);

  localparam int ADDR_W = $clog2(PROGRAM_SIZE);
  localparam int NBYTES = (INSTR_WIDTH + 7) / 8;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WORD_W = 8 * NBYTES;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e state_q, state_d;

  logic                   prog_we_q, prog_we_d;
  logic [ADDR_W-1:0]      prog_addr_q, prog_addr_d;
  logic [INSTR_WIDTH-1:0] prog_data_q, prog_data_d;
  logic [WORD_W-1:0]      word_q, word_d, word_nx;
  logic [BCNT_W-1:0]      bcnt_q, bcnt_d;
  // One bit wider than the address so LEN == PROGRAM_SIZE does not wrap.
  logic [ADDR_W:0]        wcnt_q, wcnt_d;
  logic [7:0]             len_lo_q, len_lo_d;
  logic [15:0]            len_q, len_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   hold_q, hold_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic        byte_acc, is_sync, counting, tmo_hit;
  logic        len_bad, word_end, last_word;
  logic [15:0] len_in;

  assign bus.in_ready = 1'b1;
  assign byte_acc     = bus.in_valid & bus.in_ready;
  assign is_sync      = byte_acc && (bus.in_data == SYNC_BYTE);
  assign counting     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
  // Fires on the last idle cycle of the window; a byte in this cycle is dropped.
  assign tmo_hit      = counting && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign len_in       = {bus.in_data, len_lo_q};
  assign len_bad      = (len_in == 16'd0) || (32'(len_in) > 32'(PROGRAM_SIZE));
  assign word_end     = (bcnt_q == BCNT_W'(NBYTES - 1));
  assign last_word    = ((32'(wcnt_q) + 32'd1) == 32'(len_q));

`ifdef CPU7_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (!tmo_hit && byte_acc) begin
      case (state_q)
        S_IDLE, S_DONE:            if (is_sync) csum_d = 8'h00;
        S_LEN_LO, S_LEN_HI, S_DATA: csum_d = csum_q ^ bus.in_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= 8'h00;
    else     csum_q <= csum_d;
  end
`endif

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_ERR;
    end else begin
      case (state_q)
        S_IDLE:   if (is_sync)  state_d = S_LEN_LO;
        S_LEN_LO: if (byte_acc) state_d = S_LEN_HI;
        S_LEN_HI: if (byte_acc) state_d = len_bad ? S_ERR : S_DATA;
        S_DATA: begin
          if (byte_acc && word_end && last_word) begin
`ifdef CPU7_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end
        end
`ifdef CPU7_LOADER_CHECKSUM_EN
        S_CSUM:   if (byte_acc) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
`endif
        S_DONE:   if (is_sync)  state_d = S_LEN_LO;
        S_ERR:                  state_d = S_IDLE;
        default:                state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs and datapath next values
  always_comb begin
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_data_d = prog_data_q;
    word_d      = word_q;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    hold_d      = hold_q;
    done_d      = done_q;
    err_d       = err_q;
    tmo_d       = (counting && !byte_acc && !tmo_hit) ? tmo_q + TMO_W'(1) : '0;

    word_nx = word_q;
    word_nx[{bcnt_q, 3'b000} +: 8] = bus.in_data;

    if (!tmo_hit) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (is_sync) begin
            hold_d = 1'b1;
            done_d = 1'b0;
            err_d  = 1'b0;
          end else if (state_q == S_DONE) begin
            done_d = 1'b1;
            hold_d = 1'b0;
          end
        end
        S_LEN_LO: if (byte_acc) len_lo_d = bus.in_data;
        S_LEN_HI: begin
          if (byte_acc) begin
            len_d  = len_in;
            wcnt_d = '0;
            bcnt_d = '0;
            word_d = '0;
          end
        end
        S_DATA: begin
          if (byte_acc) begin
            if (word_end) begin
              prog_we_d   = 1'b1;
              prog_addr_d = wcnt_q[ADDR_W-1:0];
              prog_data_d = word_nx[INSTR_WIDTH-1:0];
              wcnt_d      = wcnt_q + 1'b1;
              bcnt_d      = '0;
              word_d      = '0;
            end else begin
              word_d = word_nx;
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
        S_ERR: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_data_q <= '0;
      word_q      <= '0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      len_lo_q    <= 8'h00;
      len_q       <= 16'h0000;
      tmo_q       <= '0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prog_we_q   <= prog_we_d;
      prog_addr_q <= prog_addr_d;
      prog_data_q <= prog_data_d;
      word_q      <= word_d;
      bcnt_q      <= bcnt_d;
      wcnt_q      <= wcnt_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      tmo_q       <= tmo_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.prog_we   = prog_we_q;
  assign bus.prog_addr = prog_addr_q;
  assign bus.prog_data = prog_data_q;
  assign cpu_hold_o    = hold_q;
  assign load_done_o   = done_q;
  assign load_err_o    = err_q;

endmodule

// File: tb/tb_cpu7_prog_loader.sv
`timescale 1ns/1ps
// Directed bench for cpu7_prog_loader: frames, bad length, timeout, reset mid-frame.
// Latency: checks the write strobe appears the cycle after the final word byte.
// Backpressure: none expected; in_ready is checked at reset.
module tb_cpu7_prog_loader;
  localparam int PSIZE = 1024;
  localparam int IW    = 16;
  localparam int AW    = 10;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_hold, load_done, load_err;

  cpu7_prog_loader_if #(.ADDR_W(AW), .INSTR_WIDTH(IW)) bus_if ();

  cpu7_prog_loader #(
    .PROGRAM_SIZE(PSIZE), .INSTR_WIDTH(IW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if.slave),
    .cpu_hold_o(cpu_hold), .load_done_o(load_done), .load_err_o(load_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: sampled on the falling edge, one entry per strobe.
  logic [AW-1:0] wa[$];
  logic [IW-1:0] wd[$];
  int            wcy[$];
  always @(negedge clk) begin
    if (bus_if.prog_we === 1'b1) begin
      wa.push_back(bus_if.prog_addr);
      wd.push_back(bus_if.prog_data);
      wcy.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_acc = 0;
  int last_data_acc = 0;
  logic [IW-1:0] tx[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus_if.in_data  = b;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.in_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_wr();
    wa.delete();
    wd.delete();
    wcy.delete();
  endtask

  // Sends SYNC, LEN and the words in tx; appends the XOR checksum when that build is used.
  task automatic send_frame(input logic [15:0] len);
    logic [7:0] cs;
    cs = len[7:0] ^ len[15:8];
    send(8'hA5);
    send(len[7:0]);
    send(len[15:8]);
    foreach (tx[i]) begin
      send(tx[i][7:0]);
      send(tx[i][15:8]);
      cs = cs ^ tx[i][7:0] ^ tx[i][15:8];
    end
    last_data_acc = last_acc;
`ifdef CPU7_LOADER_CHECKSUM_EN
    send(cs);
`endif
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_in_ready"}, {31'd0, bus_if.in_ready}, 32'd1);
    check({pfx, "_prog_we"},  {31'd0, bus_if.prog_we},  32'd0);
    check({pfx, "_prog_addr"}, {22'd0, bus_if.prog_addr}, 32'd0);
    check({pfx, "_prog_data"}, {16'd0, bus_if.prog_data}, 32'd0);
    check({pfx, "_cpu_hold"}, {31'd0, cpu_hold},  32'd1);
    check({pfx, "_load_done"}, {31'd0, load_done}, 32'd0);
    check({pfx, "_load_err"}, {31'd0, load_err},  32'd0);
  endtask

  initial begin
    int t_start;
    int bad;
    logic in_win;
    bus_if.in_data  = 8'h00;
    bus_if.in_valid = 1'b0;

    // Reset state
    idle(3);
    check_reset("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: two-word frame
    clear_wr();
    tx = '{16'h1234, 16'hABCD};
    send_frame(16'd2);
    idle(4);
    check("t1_wr_count", wa.size(), 32'd2);
    check("t1_addr0", {22'd0, wa[0]}, 32'd0);
    check("t1_data0", {16'd0, wd[0]}, 32'h1234);
    check("t1_addr1", {22'd0, wa[1]}, 32'd1);
    check("t1_data1", {16'd0, wd[1]}, 32'hABCD);
    check("t1_wr_latency", wcy[1], last_data_acc);
    check("t1_done", {31'd0, load_done}, 32'd1);
    check("t1_hold", {31'd0, cpu_hold}, 32'd0);
    check("t1_err", {31'd0, load_err}, 32'd0);

    // 2: junk bytes ignored in DONE, SYNC restarts and re-asserts hold
    clear_wr();
    send(8'h00);
    send(8'hFF);
    check("t2_done_kept", {31'd0, load_done}, 32'd1);
    send(8'hA5);
    check("t2_hold_on_sync", {31'd0, cpu_hold}, 32'd1);
    check("t2_done_clr", {31'd0, load_done}, 32'd0);
    send(8'h01);
    send(8'h00);
    send(8'hEF);
    send(8'hBE);
`ifdef CPU7_LOADER_CHECKSUM_EN
    send(8'h50);
`endif
    idle(4);
    check("t2_wr_count", wa.size(), 32'd1);
    check("t2_data0", {16'd0, wd[0]}, 32'hBEEF);
    check("t2_done", {31'd0, load_done}, 32'd1);

    // 3: LEN = 1025 is too large
    clear_wr();
    send(8'hA5);
    send(8'h01);
    send(8'h04);
    idle(4);
    check("t3_no_write", wa.size(), 32'd0);
    check("t3_err", {31'd0, load_err}, 32'd1);
    check("t3_hold", {31'd0, cpu_hold}, 32'd1);
    check("t3_done", {31'd0, load_done}, 32'd0);
    send(8'hA5);
    check("t3_err_clr", {31'd0, load_err}, 32'd0);

    // 4: A5 01 00 11 then silence -> timeout (frame started by the A5 above)
    send(8'h01);
    send(8'h00);
    send(8'h11);
    t_start = last_acc;
    for (int k = 0; k < 100; k++) begin
      if (load_err) break;
      idle(1);
    end
    // 64 idle cycles to ERR, then one more for the registered flag.
    in_win = ((cyc - t_start) >= 64) && ((cyc - t_start) <= 66);
    check("t4_tmo_err", {31'd0, load_err}, 32'd1);
    check("t4_tmo_window", {31'd0, in_win}, 32'd1);
    check("t4_no_write", wa.size(), 32'd0);
    check("t4_hold", {31'd0, cpu_hold}, 32'd1);
    clear_wr();
    tx = '{16'h5678, 16'h1234};
    send_frame(16'd2);
    idle(4);
    check("t4_wr_count", wa.size(), 32'd2);
    check("t4_data1", {16'd0, wd[1]}, 32'h1234);
    check("t4_done", {31'd0, load_done}, 32'd1);
    check("t4_err_clr", {31'd0, load_err}, 32'd0);

    // LEN = 0 is rejected
    clear_wr();
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    idle(4);
    check("len0_err", {31'd0, load_err}, 32'd1);
    check("len0_no_write", wa.size(), 32'd0);

`ifdef CPU7_LOADER_CHECKSUM_EN
    // 5: bad checksum (correct is 32)
    clear_wr();
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h22);
    send(8'h11);
    send(8'h00);
    idle(4);
    check("t5_wr_count", wa.size(), 32'd1);
    check("t5_data0", {16'd0, wd[0]}, 32'h1122);
    check("t5_err", {31'd0, load_err}, 32'd1);
    check("t5_hold", {31'd0, cpu_hold}, 32'd1);
    check("t5_done", {31'd0, load_done}, 32'd0);
`endif

    // Full-size image: LEN == PROGRAM_SIZE must not wrap the word counter
    clear_wr();
    tx.delete();
    for (int i = 0; i < PSIZE; i++) tx.push_back(16'(i) ^ 16'h5A00);
    send_frame(16'(PSIZE));
    idle(4);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] != AW'(i) || wd[i] != (16'(i) ^ 16'h5A00)) bad++;
    end
    check("big_wr_count", wa.size(), 32'(PSIZE));
    check("big_mismatches", bad, 32'd0);
    check("big_done", {31'd0, load_done}, 32'd1);

    // 6: reset in DATA after 3 bytes
    send(8'hA5);
    send(8'h03);
    send(8'h00);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    clear_wr();
    tx = '{16'hABCD};
    send_frame(16'd1);
    idle(4);
    check("t6_wr_count", wa.size(), 32'd1);
    check("t6_addr0", {22'd0, wa[0]}, 32'd0);
    check("t6_data0", {16'd0, wd[0]}, 32'hABCD);
    check("t6_done", {31'd0, load_done}, 32'd1);
    check("t6_hold", {31'd0, cpu_hold}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global guard against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
